step_clock_gen: RTL and testbench

Execution-rate controller sitting directly upstream of the subleq CPU: turns board pushbuttons and switches into a single-cycle clock-enable pulse `oTick` that advances the CPU by one step. It supports four modes: halted, debounced manual single-step, divided free-run and full speed. The whole design then runs on one 50 MHz clock, with no derived clock. It also keeps a wrapping tick counter for the seven-segment display mux.

---
 rtl/step_clock_gen.sv | 130 +++++++++++++
 tb/tb_step_clock_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// Step-rate controller for the subleq CPU. It turns the mode switches and the step key into a
// one-cycle clock enable (oTick) and keeps a wrapping count of the ticks it has issued.
//
// mode | meaning
// -----+---------------------------------------------------------------
//  0   | halt: oTick held low, key presses discarded
//  1   | manual: one oTick per debounced key press
//  2   | divided: one oTick every PRESCALE*(L+1) cycles
//  3   | full speed: oTick high every cycle
module step_clock_gen #(
    parameter int PRESCALE        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [1:0]  iMode,
    input  logic        iStepKey,
    input  logic [7:0]  iLimit,
    output logic        oTick,
    output logic [1:0]  oMode,
    output logic [15:0] oTickCount
);

    localparam logic [1:0]  MODE_HALT = 2'd0;
    localparam logic [1:0]  MODE_STEP = 2'd1;
    localparam logic [1:0]  MODE_DIV  = 2'd2;
    localparam logic [1:0]  MODE_FULL = 2'd3;
    localparam logic [23:0] PS_LAST   = 24'(PRESCALE - 1);
    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  mode_s1;
    logic [1:0]  mode_q;
    logic        mode_chg_q;
    logic        key_s1;
    logic        key_s2;
    logic        deb_q;
    logic [23:0] db_cnt;
    logic        press_q;
    logic [23:0] pre_cnt;
    logic [7:0]  div_cnt;
    logic [7:0]  lim_q;
    logic        tick_q;
    logic [15:0] tick_cnt;

    logic        db_diff;
    logic        db_flip;
    logic [23:0] db_cnt_next;
    logic [7:0]  lim_eff;
    logic        pre_term;
    logic        div_term;
    logic [23:0] pre_next;
    logic [7:0]  div_next;
    logic        tick_next;

    // State register: synchronizers, mode, debouncer, rate counters and outputs.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            mode_s1    <= MODE_HALT;
            mode_q     <= MODE_HALT;
            mode_chg_q <= 1'b0;
            key_s1     <= 1'b1;
            key_s2     <= 1'b1;
            deb_q      <= 1'b1;
            db_cnt     <= '0;
            press_q    <= 1'b0;
            pre_cnt    <= '0;
            div_cnt    <= '0;
            lim_q      <= '0;
            tick_q     <= 1'b0;
            tick_cnt   <= '0;
        end else begin
            mode_s1    <= iMode;
            mode_q     <= mode_s1;
            mode_chg_q <= (mode_s1 != mode_q);
            key_s1     <= iStepKey;
            key_s2     <= key_s1;
            db_cnt     <= db_cnt_next;
            if (db_flip) begin
                deb_q <= key_s2;
            end
            press_q    <= db_flip & ~key_s2;
            pre_cnt    <= pre_next;
            div_cnt    <= div_next;
            lim_q      <= lim_eff;
            tick_q     <= tick_next;
            tick_cnt   <= tick_cnt + 16'(tick_next);
        end
    end

    // Next-state logic. The divider limit is captured in the first cycle of each period,
    // so a mid-period change of iLimit only affects the following period.
    always_comb begin
        db_diff     = (key_s2 != deb_q);
        db_flip     = db_diff && (db_cnt == DB_LAST);
        db_cnt_next = (db_diff && !db_flip) ? db_cnt + 24'd1 : 24'd0;

        lim_eff  = (pre_cnt == 24'd0 && div_cnt == 8'd0) ? iLimit : lim_q;
        pre_term = (pre_cnt == PS_LAST);
        div_term = (div_cnt == lim_eff);

        pre_next = 24'd0;
        div_next = 8'd0;
        if (mode_s1 == mode_q && mode_q == MODE_DIV) begin
            if (pre_term) begin
                div_next = div_term ? 8'd0 : div_cnt + 8'd1;
            end else begin
                pre_next = pre_cnt + 24'd1;
                div_next = div_cnt;
            end
        end
    end

    // Output logic. A press that lands in the cycle the mode changes is judged
    // against the previous mode and therefore dropped.
    always_comb begin
        tick_next = 1'b0;
        case (mode_q)
            MODE_HALT: tick_next = 1'b0;
            MODE_STEP: tick_next = press_q & ~mode_chg_q;
            MODE_DIV:  tick_next = pre_term & div_term;
            MODE_FULL: tick_next = 1'b1;
            default:   tick_next = 1'b0;
        endcase
    end

    assign oTick      = tick_q;
    assign oMode      = mode_q;
    assign oTickCount = tick_cnt;

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: randomized stimulus checked every cycle against an
// event-level reference model, plus directed timing checks on tick positions.
module tb_step_clock_gen;

    localparam int P = 4;
    localparam int D = 8;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic [1:0]  iMode = 2'd0;
    logic        iStepKey = 1'b1;
    logic [7:0]  iLimit = 8'd0;
    logic        oTick;
    logic [1:0]  oMode;
    logic [15:0] oTickCount;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;
    int ticks_seen = 0;
    int tick_log[$];

    step_clock_gen #(.PRESCALE(P), .DEBOUNCE_CYCLES(D)) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iMode      (iMode),
        .iStepKey   (iStepKey),
        .iLimit     (iLimit),
        .oTick      (oTick),
        .oMode      (oMode),
        .oTickCount (oTickCount)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: values describe the cycle that follows each edge.
    int m_ms1, m_mode, m_prev, m_ks1, m_ks, m_deb, m_run, m_press;
    int m_tick, m_count, m_cyc, m_pstart, m_next;
    int n_tick, n_deb, n_run;

    always @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            m_ms1 = 0; m_mode = 0; m_prev = 0;
            m_ks1 = 1; m_ks = 1; m_deb = 1; m_run = 0; m_press = 0;
            m_tick = 0; m_count = 0; m_cyc = 0; m_pstart = -1; m_next = -1;
        end else begin
            n_tick = 0;
            if (m_mode == 2) begin
                if (m_prev != 2) m_pstart = m_cyc;
                if (m_cyc == m_pstart) m_next = m_cyc + P * (int'(iLimit) + 1);
                if (m_cyc + 1 == m_next) begin
                    n_tick = 1;
                    m_pstart = m_cyc + 1;
                end
            end else if (m_mode == 3) begin
                n_tick = 1;
            end else if (m_mode == 1) begin
                n_tick = (m_press == 1 && m_prev == 1) ? 1 : 0;
            end
            // key accepted after D consecutive cycles of disagreement
            n_deb = m_deb;
            n_run = 0;
            if (m_ks != m_deb) begin
                n_run = m_run + 1;
                if (n_run == D) begin
                    n_deb = m_ks;
                    n_run = 0;
                end
            end
            m_press = (m_deb == 1 && n_deb == 0) ? 1 : 0;
            m_deb   = n_deb;
            m_run   = n_run;
            m_prev  = m_mode;
            m_mode  = m_ms1;
            m_ms1   = int'(iMode);
            m_ks    = m_ks1;
            m_ks1   = int'(iStepKey);
            m_tick  = n_tick;
            m_count = (m_count + n_tick) % 65536;
            m_cyc++;
        end
    end

    always @(posedge iClock) tb_cyc++;

    always @(negedge iClock) begin
        check("cyc_tick", 32'(oTick), 32'(m_tick));
        check("cyc_mode", 32'(oMode), 32'(m_mode));
        check("cyc_count", 32'(oTickCount), 32'(m_count));
        if (oTick) begin
            ticks_seen++;
            tick_log.push_back(tb_cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic wait_mode(input logic [1:0] m);
        for (int i = 0; i < 20 && oMode != m; i++) step(1);
        check("mode_wait", 32'(oMode), 32'(m));
    endtask

    int base, c, fall, lvl, elapsed, seg, lim, r;

    initial begin
        // reset state
        #12;
        check("rst_tick", 32'(oTick), 0);
        check("rst_mode", 32'(oMode), 0);
        check("rst_count", 32'(oTickCount), 0);
        iMode = 2'd1;
        @(posedge iClock); #1;
        iReset = 1'b1;
        wait_mode(2'd1);
        step(2);

        // clean manual press
        base = ticks_seen;
        tick_log.delete();
        iStepKey = 1'b0;
        fall = tb_cyc;
        step(20);
        check("t1_pulses", ticks_seen - base, 1);
        if (tick_log.size() > 0) check("t1_latency", tick_log[0] - fall, 2 + D + 1);
        check("t1_count", 32'(oTickCount), 1);
        iStepKey = 1'b1;
        step(20);

        // bounce shorter than the debounce window, then settle low
        base = ticks_seen;
        lvl = 0;
        elapsed = 0;
        while (elapsed < 30) begin
            seg = $urandom_range(1, 5);
            iStepKey = lvl[0];
            step(seg);
            elapsed += seg;
            lvl ^= 1;
        end
        iStepKey = 1'b1;
        step(1);
        check("t2_bounce", ticks_seen - base, 0);
        tick_log.delete();
        iStepKey = 1'b0;
        fall = tb_cyc;
        step(20);
        check("t2_pulses", ticks_seen - base, 1);
        if (tick_log.size() > 0) check("t2_latency", tick_log[0] - fall, 2 + D + 1);
        iStepKey = 1'b1;
        step(20);

        // divided run, limit 2
        iLimit = 8'd2;
        iMode = 2'd2;
        wait_mode(2'd2);
        c = tb_cyc;
        tick_log.delete();
        step(61);
        check("t3_ticks", tick_log.size(), 5);
        for (int i = 0; i < tick_log.size(); i++)
            check("t3_tick_pos", tick_log[i] - c, 12 * (i + 1));

        // limit changed mid-period: current period keeps 12, later ones are 4
        r = $urandom_range(0, 8);
        step(r);
        iLimit = 8'd0;
        tick_log.delete();
        step((c + 81) - tb_cyc);
        check("t4_ticks", tick_log.size(), 3);
        for (int i = 0; i < tick_log.size(); i++)
            check("t4_tick_pos", tick_log[i] - c, 72 + 4 * i);

        // random limit, fresh entry into divided mode
        for (int k = 0; k < 3; k++) begin
            lim = $urandom_range(0, 5);
            iMode = 2'd0;
            step(4);
            iLimit = 8'(lim);
            iMode = 2'd2;
            wait_mode(2'd2);
            c = tb_cyc;
            tick_log.delete();
            step(3 * P * (lim + 1) + 1);
            check("t4r_ticks", tick_log.size(), 3);
            if (tick_log.size() > 0) check("t4r_first", tick_log[0] - c, P * (lim + 1));
        end

        // full speed across the counter wrap, starting from reset
        iMode = 2'd0;
        iReset = 1'b0;
        step(2);
        iReset = 1'b1;
        step(2);
        iMode = 2'd3;
        wait_mode(2'd3);
        base = ticks_seen;
        step(70000);
        check("t5_count", 32'(oTickCount), 4464);
        step(1);
        check("t5_ticks", ticks_seen - base, 70000);

        // asynchronous reset mid-cycle in full speed
        @(posedge iClock);
        #3;
        iReset = 1'b0;
        #1;
        check("t6_rst_tick", 32'(oTick), 0);
        check("t6_rst_mode", 32'(oMode), 0);
        check("t6_rst_count", 32'(oTickCount), 0);
        iMode = 2'd0;
        step(2);
        iReset = 1'b1;
        step(4);
        base = ticks_seen;
        iStepKey = 1'b0;
        step(20);
        iStepKey = 1'b1;
        step(20);
        check("t6_halt_press", ticks_seen - base, 0);

        // press event coinciding with the switch into manual mode
        base = ticks_seen;
        iStepKey = 1'b0;
        step(8);
        iMode = 2'd1;
        step(20);
        check("t7_simul_press", ticks_seen - base, 0);
        iStepKey = 1'b1;
        step(20);

        // random manual presses
        base = ticks_seen;
        for (int k = 0; k < 4; k++) begin
            iStepKey = 1'b0;
            step($urandom_range(12, 30));
            iStepKey = 1'b1;
            step($urandom_range(12, 20));
        end
        check("t8_presses", ticks_seen - base, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
